// File: rtl/imem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between instruction fetch and load/store.
// Define IMEM_ARB_PERF_EN to add the perf_if_wait_o / perf_dm_wait_o stall-cycle counters.
module imem_port_arbiter #(
   parameter int unsigned MEM_LATENCY  = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        flush_i,
   output logic [31:0] if_rdata_o,
   output logic        if_valid_o,
   output logic        stall_if_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   input  logic [3:0]  dm_be_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_valid_o,
   output logic        stall_mem_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic [31:0] mem_rdata_i
`ifdef IMEM_ARB_PERF_EN
   ,
   output logic [31:0] perf_if_wait_o,
   output logic [31:0] perf_dm_wait_o
`endif
);

   localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
   localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             cancel_q, cancel_d;
   logic             we_q, we_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [31:0]      dm_rdata_q, dm_rdata_d;
   logic             force_if, grant_if, grant_dm, if_done, dm_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         cancel_q   <= 1'b0;
         we_q       <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         cancel_q   <= cancel_d;
         we_q       <= we_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      starve_d   = starve_q;
      cancel_d   = cancel_q;
      we_d       = we_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      force_if   = 1'b0;
      grant_if   = 1'b0;
      grant_dm   = 1'b0;
      if_done    = 1'b0;
      dm_done    = 1'b0;
      case (state_q)
         IDLE: begin
            // No issue while reset is held, so nothing escapes to memory that the FSM would forget.
            if (rst_ni) begin
               force_if = if_req_i & ~flush_i & (starve_q == STARVE_MAX);
               grant_dm = dm_req_i & ~force_if;
               grant_if = if_req_i & ~flush_i & ~grant_dm;
            end
            if (grant_dm) begin
               state_d = BUSY_DM;
               cnt_d   = LAT_LOAD;
               we_d    = dm_we_i;
            end else if (grant_if) begin
               state_d  = BUSY_IF;
               cnt_d    = LAT_LOAD;
               cancel_d = 1'b0;
            end
         end
         BUSY_IF: begin
            if (flush_i) cancel_d = 1'b1;
            if (cnt_q == '0) begin
               state_d  = IDLE;
               cancel_d = 1'b0;
               // A redirect landing on the completion cycle also drops the stale instruction.
               if (!cancel_q && !flush_i) begin
                  if_done    = 1'b1;
                  if_rdata_d = mem_rdata_i;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BUSY_DM: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               dm_done = 1'b1;
               if (!we_q) dm_rdata_d = mem_rdata_i;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (grant_if || !if_req_i)                        starve_d = '0;
      else if (grant_dm && (starve_q != STARVE_MAX))    starve_d = starve_q + 1'b1;
   end

   assign mem_en_o    = grant_if | grant_dm;
   assign mem_we_o    = grant_dm & dm_we_i;
   assign mem_addr_o  = grant_dm ? dm_addr_i  : (grant_if ? if_addr_i : '0);
   assign mem_wdata_o = grant_dm ? dm_wdata_i : '0;
   assign mem_be_o    = grant_dm ? dm_be_i    : '0;

   // Read data is forwarded in the completion cycle and held in the _q register afterwards.
   assign if_valid_o  = if_done;
   assign dm_valid_o  = dm_done;
   assign if_rdata_o  = if_done ? mem_rdata_i : if_rdata_q;
   assign dm_rdata_o  = (dm_done && !we_q) ? mem_rdata_i : dm_rdata_q;
   assign stall_if_o  = if_req_i & ~if_valid_o;
   assign stall_mem_o = dm_req_i & ~dm_valid_o;

`ifdef IMEM_ARB_PERF_EN
   logic [31:0] perf_if_q, perf_dm_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_if_q <= '0;
         perf_dm_q <= '0;
      end else begin
         if (stall_if_o)  perf_if_q <= perf_if_q + 32'd1;
         if (stall_mem_o) perf_dm_q <= perf_dm_q + 32'd1;
      end
   end

   assign perf_if_wait_o = perf_if_q;
   assign perf_dm_wait_o = perf_dm_q;
`endif

endmodule
